mole_hit_detector: RTL

Player-side input receiver for whack-a-mole: conditions the five raw slide switches and judges each debounced toggle against the currently lit mole pattern. Emits one-cycle hit/miss strobes and keeps a saturating hit count. Sits between the switch pins and the score counter/display path, on the opposite end of the mole LED pattern that the random mole generator drives.

---
 rtl/mole_pkg.sv | 13 +
 rtl/switch_debouncer.sv | 41 ++++
 rtl/mole_hit_detector.sv | 86 ++++++++
 3 files changed

// File: rtl/mole_pkg.sv
// Shared defaults and FSM encoding for the whack-a-mole switch receiver.
package mole_pkg;

  localparam int NUM_MOLES_DEF       = 5;
  localparam int DEBOUNCE_CYCLES_DEF = 100000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    HIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/switch_debouncer.sv
// One switch bit: 2-flop synchronizer followed by a stable-run debounce counter.
module switch_debouncer
  import mole_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_s1, r_s2, r_db;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      // Any sample agreeing with the accepted level restarts the run.
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/mole_hit_detector.sv
// Judges debounced switch toggles against the lit mole pattern; hit/miss strobes + saturating count.
// Optional MISS_PENALTY_EN: each miss also decrements hit_count, floored at 0.
module mole_hit_detector
  import mole_pkg::*;
#(
  parameter int NUM_MOLES       = NUM_MOLES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mole_valid,
  input  logic                 mole_new,
  input  logic [NUM_MOLES-1:0] mole_in,
  input  logic [NUM_MOLES-1:0] switch_in,
  output logic [NUM_MOLES-1:0] switch_db,
  output logic                 hit,
  output logic                 miss,
  output logic [CNT_W-1:0]     hit_count
);

  logic [NUM_MOLES-1:0] w_db, w_tog, r_db_prev, r_pat;
  logic                 w_judge, w_hit, w_miss, r_hit, r_miss;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  state_t               r_state, w_state_nxt;

  for (genvar g = 0; g < NUM_MOLES; g++) begin : g_sw
    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .i_raw (switch_in[g]),
      .o_db  (w_db[g])
    );
  end

  assign w_tog   = w_db ^ r_db_prev;
  assign w_judge = mole_valid && (r_state == ARMED) && (|w_tog);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pat     <= '0;
      r_db_prev <= '0;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_db_prev <= w_db;
      r_hit     <= w_hit;
      r_miss    <= w_miss;
      r_cnt     <= w_cnt_nxt;
      if (mole_valid && mole_new) r_pat <= mole_in;
    end
  end

  // A new pattern overrides the post-hit lockout; the toggle is judged on the old pattern.
  always_comb begin
    w_state_nxt = r_state;
    if (!mole_valid)
      w_state_nxt = IDLE;
    else if (mole_new)
      w_state_nxt = ARMED;
    else if (w_hit)
      w_state_nxt = HIT_DONE;
    else if (r_state != IDLE && r_state != ARMED && r_state != HIT_DONE)
      w_state_nxt = IDLE;
  end

  always_comb begin
    w_hit     = w_judge && (|(w_tog & r_pat));
    w_miss    = w_judge && !w_hit;
    w_cnt_nxt = r_cnt;
    if (w_hit && (r_cnt != '1)) w_cnt_nxt = r_cnt + CNT_W'(1);
`ifdef MISS_PENALTY_EN
    if (w_miss && (r_cnt != '0)) w_cnt_nxt = r_cnt - CNT_W'(1);
`else
`endif
  end

  assign switch_db = w_db;
  assign hit       = r_hit;
  assign miss      = r_miss;
  assign hit_count = r_cnt;

endmodule
